// File: rtl/hwpe_ctrl_package.sv
// Shared constants and types for the HWPE control slice.
// The event-buffer additions sit alongside the existing register-file sizing.
package hwpe_ctrl_package;

   // Register-file sizing already used by the control slave.
   localparam int unsigned REGFILE_N_EVT       = 4;
   localparam int unsigned REGFILE_N_MAX_CORES = 16;

   // Event buffer: default width of each pending-event counter.
   localparam int unsigned EVT_BUF_CNT_WIDTH   = 2;

   // Per-core status of the event buffer.
   // Sized for the largest supported cluster.
   typedef struct packed {
      logic [REGFILE_N_MAX_CORES-1:0] pending;
      logic [REGFILE_N_MAX_CORES-1:0] overflow;
   } evt_buf_flags_t;

endpackage

// File: rtl/hwpe_ctrl_evt_counter.sv
// Saturating up/down pending-event counter for one core/event line.
// A push and a pop in the same cycle cancel, so a full counter never
// overflows while it is being drained. ovf_pulse flags a push that was
// dropped because the counter was already full.
module hwpe_ctrl_evt_counter
   import hwpe_ctrl_package::*;
#(
   parameter int unsigned CNT_WIDTH = EVT_BUF_CNT_WIDTH
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear,
   input  logic                 push,
   input  logic                 pop,
   output logic [CNT_WIDTH-1:0] cnt,
   output logic                 nonzero,
   output logic                 ovf_pulse
);

   localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

   logic [CNT_WIDTH-1:0] cnt_r;
   logic [CNT_WIDTH-1:0] cnt_d_s;
   logic                 ovf_s;

   // Next count: clear dominates, then push-only, pop-only, otherwise hold.
   always_comb begin
      cnt_d_s = cnt_r;
      ovf_s   = 1'b0;
      if (clear) begin
         cnt_d_s = CNT_ZERO;
      end else if (push && !pop) begin
         if (cnt_r == CNT_MAX) begin
            ovf_s = 1'b1;
         end else begin
            cnt_d_s = cnt_r + CNT_ONE;
         end
      end else if (pop && !push) begin
         if (cnt_r != CNT_ZERO) begin
            cnt_d_s = cnt_r - CNT_ONE;
         end else begin
            cnt_d_s = CNT_ZERO;
         end
      end else begin
         cnt_d_s = cnt_r;
      end
   end

   // Counter state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_r <= CNT_ZERO;
      end else begin
         cnt_r <= cnt_d_s;
      end
   end

   assign cnt       = cnt_r;
   assign nonzero   = (cnt_r != CNT_ZERO);
   assign ovf_pulse = ovf_s;

endmodule

// File: rtl/hwpe_ctrl_evt_buffer.sv
// Per-core, per-line event buffer between the control slave event flags
// and the cluster event unit. Every event pulse is stored in a saturating
// counter and drained with a per-core valid/ready handshake. Valid and
// pending outputs depend on registers only. Dropped events raise a sticky
// per-core overflow flag.
module hwpe_ctrl_evt_buffer
   import hwpe_ctrl_package::*;
#(
   parameter int unsigned N_CORES   = 4,
   parameter int unsigned N_EVT     = REGFILE_N_EVT,
   parameter int unsigned CNT_WIDTH = EVT_BUF_CNT_WIDTH
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            clear_i,
   input  logic [N_CORES-1:0][N_EVT-1:0]   evt_i,
   output logic [N_CORES-1:0][N_EVT-1:0]   evt_valid_o,
   input  logic [N_CORES-1:0]              evt_ready_i,
   output logic [N_CORES-1:0]              pending_o,
   output logic [N_CORES-1:0]              overflow_o,
   input  logic [N_CORES-1:0]              overflow_clr_i
);

   logic [N_CORES-1:0][N_EVT-1:0] valid_s;
   logic [N_CORES-1:0][N_EVT-1:0] pop_s;
   logic [N_CORES-1:0][N_EVT-1:0] ovf_pulse_s;
   logic [CNT_WIDTH-1:0]          cnt_s [N_CORES][N_EVT];

   logic [N_CORES-1:0]            overflow_r;
   logic [N_CORES-1:0]            overflow_d_s;
   evt_buf_flags_t                flags_s;
   logic                          flags_unused_s;

   // One counter per core and event line; a ready core pops all its valid lines.
   for (genvar c = 0; c < N_CORES; c++) begin : gen_core
      for (genvar e = 0; e < N_EVT; e++) begin : gen_evt
         assign pop_s[c][e] = valid_s[c][e] & evt_ready_i[c];

         hwpe_ctrl_evt_counter #(
            .CNT_WIDTH ( CNT_WIDTH )
         ) i_evt_counter (
            .clk_i     ( clk_i             ),
            .rst_ni    ( rst_ni            ),
            .clear     ( clear_i           ),
            .push      ( evt_i[c][e]       ),
            .pop       ( pop_s[c][e]       ),
            .cnt       ( cnt_s[c][e]       ),
            .nonzero   ( valid_s[c][e]     ),
            .ovf_pulse ( ovf_pulse_s[c][e] )
         );
      end
   end

   // Sticky overflow next state: a new drop on any line beats a same-cycle clear.
   always_comb begin
      overflow_d_s = {N_CORES{1'b0}};
      for (int unsigned c = 0; c < N_CORES; c++) begin
         overflow_d_s[c] = (overflow_r[c] & ~overflow_clr_i[c]) | (|ovf_pulse_s[c]);
      end
   end

   // Sticky overflow register; soft clear wipes it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         overflow_r <= {N_CORES{1'b0}};
      end else if (clear_i) begin
         overflow_r <= {N_CORES{1'b0}};
      end else begin
         overflow_r <= overflow_d_s;
      end
   end

   // Per-core status: pending is the OR over that core's counters.
   always_comb begin
      flags_s = '0;
      for (int unsigned c = 0; c < N_CORES; c++) begin
         for (int unsigned e = 0; e < N_EVT; e++) begin
            flags_s.pending[c] = flags_s.pending[c] | (|cnt_s[c][e]);
         end
         flags_s.overflow[c] = overflow_r[c];
      end
   end

   // Flag bits above N_CORES stay zero and are not routed out.
   assign flags_unused_s = ^flags_s;

   assign evt_valid_o = valid_s;
   assign pending_o   = flags_s.pending[N_CORES-1:0];
   assign overflow_o  = flags_s.overflow[N_CORES-1:0];

endmodule

// File: tb/tb_hwpe_ctrl_evt_buffer.sv
// Self-checking bench for hwpe_ctrl_evt_buffer: a reference model predicts
// the outputs after each driven cycle, the prediction is queued, and it is
// popped and compared once the DUT has taken the clock edge.
module tb_hwpe_ctrl_evt_buffer;

   localparam int NC   = 4;
   localparam int NE   = 4;
   localparam int CMAX = 3;

   logic                   clk_i = 1'b0;
   logic                   rst_ni;
   logic                   clear_i;
   logic [NC-1:0][NE-1:0]  evt_i;
   logic [NC-1:0][NE-1:0]  evt_valid_o;
   logic [NC-1:0]          evt_ready_i;
   logic [NC-1:0]          pending_o;
   logic [NC-1:0]          overflow_o;
   logic [NC-1:0]          overflow_clr_i;

   always #5 clk_i = ~clk_i;

   hwpe_ctrl_evt_buffer #(
      .N_CORES   ( NC ),
      .N_EVT     ( NE ),
      .CNT_WIDTH ( 2  )
   ) i_dut (
      .clk_i          ( clk_i          ),
      .rst_ni         ( rst_ni         ),
      .clear_i        ( clear_i        ),
      .evt_i          ( evt_i          ),
      .evt_valid_o    ( evt_valid_o    ),
      .evt_ready_i    ( evt_ready_i    ),
      .pending_o      ( pending_o      ),
      .overflow_o     ( overflow_o     ),
      .overflow_clr_i ( overflow_clr_i )
   );

   typedef struct packed {
      logic [15:0] valid;
      logic [3:0]  pend;
      logic [3:0]  ovf;
   } exp_t;

   exp_t       exp_q[$];
   int         m_cnt [NC][NE];
   logic [3:0] m_ovf;
   int         checks   = 0;
   int         failures = 0;
   int         n_pop;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] bitv(input int c, input int e);
      logic [15:0] one_v;
      one_v = 16'd1;
      return one_v << (c * NE + e);
   endfunction

   function automatic exp_t model_out();
      exp_t r;
      r = '0;
      for (int c = 0; c < NC; c++) begin
         for (int e = 0; e < NE; e++) begin
            if (m_cnt[c][e] > 0) begin
               r.valid[c*NE+e] = 1'b1;
               r.pend[c]       = 1'b1;
            end
         end
      end
      r.ovf = m_ovf;
      return r;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NC; c++)
         for (int e = 0; e < NE; e++)
            m_cnt[c][e] = 0;
      m_ovf = 4'h0;
   endtask

   // Drive one cycle of stimulus, predict, then compare after the edge.
   task automatic step(input logic [15:0] ev, input logic [3:0] rd,
                       input logic cl, input logic [3:0] oc);
      logic [3:0] set_v;
      exp_t       got_e;
      bit         p;
      bit         q;
      evt_i          = ev;
      evt_ready_i    = rd;
      clear_i        = cl;
      overflow_clr_i = oc;
      set_v = 4'h0;
      for (int c = 0; c < NC; c++) begin
         for (int e = 0; e < NE; e++) begin
            p = ev[c*NE+e];
            q = (m_cnt[c][e] > 0) && rd[c];
            if (cl)               m_cnt[c][e] = 0;
            else if (p && !q) begin
               if (m_cnt[c][e] == CMAX) set_v[c] = 1'b1;
               else                     m_cnt[c][e] = m_cnt[c][e] + 1;
            end
            else if (q && !p)     m_cnt[c][e] = m_cnt[c][e] - 1;
         end
      end
      m_ovf = cl ? 4'h0 : ((m_ovf & ~oc) | set_v);
      exp_q.push_back(model_out());
      @(posedge clk_i);
      #1;
      got_e = exp_q.pop_front();
      check_eq("valid",    32'(evt_valid_o), 32'(got_e.valid));
      check_eq("pending",  32'(pending_o),   32'(got_e.pend));
      check_eq("overflow", 32'(overflow_o),  32'(got_e.ovf));
   endtask

   initial begin
      rst_ni         = 1'b0;
      clear_i        = 1'b0;
      evt_i          = '0;
      evt_ready_i    = '0;
      overflow_clr_i = '0;
      model_reset();
      repeat (2) @(posedge clk_i);
      #1;
      check_eq("rst_valid",    32'(evt_valid_o), 32'd0);
      check_eq("rst_pending",  32'(pending_o),   32'd0);
      check_eq("rst_overflow", 32'(overflow_o),  32'd0);
      rst_ni = 1'b1;
      step(16'h0, 4'h0, 1'b0, 4'h0);

      // Single pulse with ready high: valid for exactly one cycle.
      step(bitv(1, 0), 4'hF, 1'b0, 4'h0);
      check_eq("single_valid", 32'(evt_valid_o[1][0]), 32'd1);
      check_eq("single_pend",  32'(pending_o), 32'h2);
      step(16'h0, 4'hF, 1'b0, 4'h0);
      check_eq("single_gone",  32'(evt_valid_o[1][0]), 32'd0);

      // Back-pressure: three events held, then drained in three cycles.
      repeat (3) step(bitv(0, 2), 4'h0, 1'b0, 4'h0);
      step(16'h0, 4'h0, 1'b0, 4'h0);
      check_eq("bp_no_ovf", 32'(overflow_o), 32'd0);
      n_pop = 0;
      repeat (5) begin
         n_pop += int'(evt_valid_o[0][2]);
         step(16'h0, 4'h1, 1'b0, 4'h0);
      end
      check_eq("bp_drain_len", 32'(n_pop), 32'd3);

      // Overflow: fourth pulse dropped, sticky flag, three drained.
      repeat (4) step(bitv(0, 0), 4'h0, 1'b0, 4'h0);
      check_eq("ovf_set", 32'(overflow_o[0]), 32'd1);
      n_pop = 0;
      repeat (5) begin
         n_pop += int'(evt_valid_o[0][0]);
         step(16'h0, 4'h1, 1'b0, 4'h0);
      end
      check_eq("ovf_drain_len", 32'(n_pop), 32'd3);
      step(16'h0, 4'h0, 1'b0, 4'h1);
      check_eq("ovf_clr", 32'(overflow_o[0]), 32'd0);
      repeat (3) step(bitv(0, 0), 4'h0, 1'b0, 4'h0);
      step(bitv(0, 0), 4'h0, 1'b0, 4'h1);
      check_eq("ovf_set_wins", 32'(overflow_o[0]), 32'd1);
      step(16'h0, 4'h0, 1'b0, 4'h1);
      repeat (4) step(16'h0, 4'h1, 1'b0, 4'h0);

      // Simultaneous push and pop at full count: no overflow, count kept.
      repeat (3) step(bitv(2, 1), 4'h0, 1'b0, 4'h0);
      step(bitv(2, 1), 4'h4, 1'b0, 4'h0);
      check_eq("pp_no_ovf", 32'(overflow_o[2]), 32'd0);
      n_pop = 0;
      repeat (5) begin
         n_pop += int'(evt_valid_o[2][1]);
         step(16'h0, 4'h4, 1'b0, 4'h0);
      end
      check_eq("pp_drain_len", 32'(n_pop), 32'd3);

      // Clear with pending counts and a new event in the same cycle.
      repeat (2) step(bitv(0, 1) | bitv(2, 3), 4'h0, 1'b0, 4'h0);
      step(bitv(1, 0), 4'h0, 1'b1, 4'h0);
      check_eq("clr_valid", 32'(evt_valid_o), 32'd0);
      check_eq("clr_ovf",   32'(overflow_o),  32'd0);
      step(16'h0, 4'hF, 1'b0, 4'h0);

      // Random traffic with occasional clears and overflow clears.
      repeat (300) begin
         step(16'($urandom & $urandom), 4'($urandom),
              ($urandom_range(0, 31) == 0),
              ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0);
      end

      // Asynchronous reset with counters loaded.
      repeat (4) step(16'hFFFF, 4'h0, 1'b0, 4'h0);
      #1;
      rst_ni = 1'b0;
      #1;
      check_eq("arst_valid",    32'(evt_valid_o), 32'd0);
      check_eq("arst_pending",  32'(pending_o),   32'd0);
      check_eq("arst_overflow", 32'(overflow_o),  32'd0);
      model_reset();
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      repeat (3) step(16'h0, 4'h0, 1'b0, 4'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
